shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 24 ++
 rtl/shift_sequencer_if.sv | 30 +++
 rtl/shift_sequencer_step.sv | 27 ++
 rtl/shift_sequencer.sv | 104 ++++++++++
 tb/tb_shift_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: shift modes, FSM states and
// the per-cycle step limit.
package shift_sequencer_pkg;

    // Largest number of positions moved in one SHIFT cycle (2-bit step amount).
    localparam int STEP_MAX = 3;

    // Shift operations; encodings 5..7 are reserved and execute as LSL.
    typedef enum logic [2:0] {
        MODE_LSL = 3'd0,
        MODE_ROL = 3'd1,
        MODE_LSR = 3'd2,
        MODE_ASR = 3'd3,
        MODE_ROR = 3'd4
    } mode_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a requester and the shift sequencer.
//
// Handshake: the requester drives Start with DataA/ShiftAmount/ShifterMode;
// the request is taken at a rising edge only when Busy=0 (IDLE). Once taken,
// Busy stays high until the operation ends, and the input fields may change
// freely. Done pulses high for exactly one cycle when Result becomes valid;
// Result then holds until the next Done.
interface shift_sequencer_if #(
    parameter int DataWidth = 32
);
    localparam int AmtWidth = $clog2(DataWidth);

    logic                 Start;
    logic [DataWidth-1:0] DataA;
    logic [AmtWidth-1:0]  ShiftAmount;
    logic [2:0]           ShifterMode;
    logic                 Busy;
    logic                 Done;
    logic [DataWidth-1:0] Result;

    modport master (
        output Start, DataA, ShiftAmount, ShifterMode,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, DataA, ShiftAmount, ShifterMode,
        output Busy, Done, Result
    );
endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational single-pass shifter: moves a word by 0..3 positions in the
// selected mode. Reserved mode encodings fall through to LSL.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] data_in,
    input  logic [1:0]           step,
    input  logic [2:0]           mode,
    output logic [DataWidth-1:0] data_out
);

    // Select the shifted word; a right shift by DataWidth yields zero, so a
    // rotate by 0 collapses to the input word.
    always_comb begin
        data_out = data_in << step;
        case (mode)
            MODE_ROL: data_out = (data_in << step) | (data_in >> (DataWidth - int'(step)));
            MODE_LSR: data_out = data_in >> step;
            MODE_ASR: data_out = $unsigned($signed(data_in) >>> step);
            MODE_ROR: data_out = (data_in >> step) | (data_in << (DataWidth - int'(step)));
            default:  data_out = data_in << step;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shift sequencer: latches an operand, then shifts it by
// up to StepMax positions per cycle until the requested distance is covered,
// and presents the registered result with a one-cycle Done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int StepMax   = STEP_MAX
) (
    input  logic                    Clock,
    input  logic                    nReset,
    shift_sequencer_if.slave        bus,
    output state_e                  dbg_state
);

    localparam int AmtWidth = $clog2(DataWidth);

    state_e               state_q, state_d;
    logic [DataWidth-1:0] work_q, work_d;
    logic [AmtWidth-1:0]  remaining_q, remaining_d;
    logic [2:0]           mode_q, mode_d;
    logic [DataWidth-1:0] result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           step;
    logic [DataWidth-1:0] step_out;

    shift_step #(
        .DataWidth(DataWidth)
    ) u_shift_step (
        .data_in  (work_q),
        .step     (step),
        .mode     (mode_q),
        .data_out (step_out)
    );

    // Next-state, datapath and registered-output logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        result_d    = result_q;
        step        = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    work_d      = bus.DataA;
                    remaining_d = bus.ShiftAmount;
                    mode_d      = bus.ShifterMode;
                    state_d     = (bus.ShiftAmount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Step is clamped to what is left so Remaining cannot underflow.
                step        = (remaining_q > AmtWidth'(StepMax)) ? 2'(StepMax) : remaining_q[1:0];
                work_d      = step_out;
                remaining_d = remaining_q - AmtWidth'(step);
                if (remaining_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Result captures the final word on the edge that enters DONE.
        if (state_d == ST_DONE) begin
            result_d = work_d;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            remaining_q <= '0;
            mode_q      <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus random
// operations compared against a whole-distance shift model.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    localparam int W = 32;

    logic   Clock;
    logic   nReset;
    state_e dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    shift_sequencer_if #(.DataWidth(W)) bus ();

    shift_sequencer #(
        .DataWidth(W),
        .StepMax  (3)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Comparison helper
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: full-distance shift in one arithmetic expression.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input int n, input int m);
        logic [W-1:0] r;
        case (m)
            1:       r = (n == 0) ? a : ((a << n) | (a >> (W - n)));
            2:       r = a >> n;
            3:       r = $unsigned($signed(a) >>> n);
            4:       r = (n == 0) ? a : ((a >> n) | (a << (W - n)));
            default: r = a << n;
        endcase
        return r;
    endfunction

    // Driver: issue one request and follow it to Done. Called #1 after a
    // rising edge with the sequencer idle. With poke set, Start is held high
    // with fresh random inputs throughout the operation.
    task automatic do_op(input logic [W-1:0] a, input int n, input int m,
                         input bit poke, input string tag);
        int edges;
        int busy_cnt;
        int done_cnt;
        int exp_lat;
        logic [W-1:0] exp_r;
        check({tag, "_idle"}, 64'(bus.Busy), 64'd0);
        bus.Start       = 1'b1;
        bus.DataA       = a;
        bus.ShiftAmount = 5'(n);
        bus.ShifterMode = 3'(m);
        exp_q.push_back(model(a, n, m));
        exp_lat  = (n + 2) / 3 + 1;
        edges    = 0;
        busy_cnt = 0;
        done_cnt = 0;
        while (done_cnt == 0 && edges < 60) begin
            @(posedge Clock);
            #1;
            edges++;
            if (bus.Busy) busy_cnt++;
            if (bus.Done) done_cnt++;
            if (poke) begin
                bus.Start       = 1'b1;
                bus.DataA       = $urandom;
                bus.ShiftAmount = 5'($urandom_range(0, 31));
                bus.ShifterMode = 3'($urandom_range(0, 7));
            end else begin
                bus.Start = 1'b0;
            end
        end
        exp_r = exp_q.pop_front();
        check({tag, "_done"}, 64'(done_cnt), 64'd1);
        check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(edges));
        check({tag, "_result"}, 64'(bus.Result), 64'(exp_r));
        // Edge after DONE: back to idle, pulse gone, result held.
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        check({tag, "_pulse"}, 64'(bus.Done), 64'd0);
        check({tag, "_busy_end"}, 64'(bus.Busy), 64'd0);
        check({tag, "_hold"}, 64'(bus.Result), 64'(exp_r));
    endtask

    // Main sequence
    initial begin
        int done_seen;
        nReset          = 1'b1;
        bus.Start       = 1'b0;
        bus.DataA       = '0;
        bus.ShiftAmount = '0;
        bus.ShifterMode = '0;
        #2 nReset = 1'b0;
        #2;
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_result", 64'(bus.Result), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        @(posedge Clock);
        #1;

        do_op(32'h80000001, 0, 0, 1'b0, "lsl0");
        do_op(32'h00000001, 31, 0, 1'b0, "lsl31");
        do_op(32'h80000000, 7, 3, 1'b0, "asr7");
        do_op(32'h80000000, 7, 2, 1'b0, "lsr7");
        do_op(32'h12345678, 4, 4, 1'b0, "ror4");
        do_op(32'h12345678, 8, 1, 1'b0, "rol8");
        do_op(32'hDEADBEEF, 10, 0, 1'b1, "poke10");
        do_op(32'h0000F00F, 5, 6, 1'b0, "rsvd6");
        do_op(32'hC0000003, 31, 1, 1'b0, "rol31");
        do_op(32'hC0000003, 31, 3, 1'b0, "asr31");

        // Abort by reset in the middle of a 20-position shift.
        bus.Start       = 1'b1;
        bus.DataA       = $urandom;
        bus.ShiftAmount = 5'd20;
        bus.ShifterMode = 3'd0;
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("abort_busy_mid", 64'(bus.Busy), 64'd1);
        #2 nReset = 1'b0;
        #1;
        check("abort_busy", 64'(bus.Busy), 64'd0);
        check("abort_done", 64'(bus.Done), 64'd0);
        check("abort_result", 64'(bus.Result), 64'd0);
        @(negedge Clock);
        nReset    = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(posedge Clock);
            #1;
            if (bus.Done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        do_op(32'h0F0F0F0F, 20, 0, 1'b0, "post_abort");

        // Random operations, including reserved modes.
        for (int i = 0; i < 25; i++) begin
            do_op($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
